// File: rtl/time_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// time_ctrl_pkg
// Shared types and constants for the time-setting controller:
//   state_t      : controller FSM states (RUN and the three edit states)
//   FIELD_*      : encodings driven on set_field
//   MAX_HR       : highest hour value (23); wraps to 0
//   MAX_MIN_SEC  : highest minute/second value (59); wraps to 0
//   inc_hr / inc_min_sec : wrapping increment helpers for the shadow fields
// ---------------------------------------------------------------------------
package time_ctrl_pkg;

  localparam int SEC_W = 6;
  localparam int MIN_W = 6;
  localparam int HR_W  = 5;

  localparam logic [HR_W-1:0]  MAX_HR      = 5'd23;
  localparam logic [SEC_W-1:0] MAX_MIN_SEC = 6'd59;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2,
    SET_SEC = 2'd3
  } state_t;

  localparam logic [1:0] FIELD_NONE = 2'b00;
  localparam logic [1:0] FIELD_HR   = 2'b01;
  localparam logic [1:0] FIELD_MIN  = 2'b10;
  localparam logic [1:0] FIELD_SEC  = 2'b11;

  // '>=' rather than '==' so an out-of-range value captured from the live
  // counter still recovers to 0 on the next increment.
  function automatic logic [HR_W-1:0] inc_hr(input logic [HR_W-1:0] v);
    return (v >= MAX_HR) ? '0 : v + 1'b1;
  endfunction

  function automatic logic [SEC_W-1:0] inc_min_sec(input logic [SEC_W-1:0] v);
    return (v >= MAX_MIN_SEC) ? '0 : v + 1'b1;
  endfunction

endpackage

// File: rtl/btn_repeat.sv
// ---------------------------------------------------------------------------
// btn_repeat
// Rising-edge detector with hold-to-repeat for a debounced, synchronised
// button level. An event is produced on the press edge, then REPEAT_DLY
// cycles later if still held, then every REPEAT_PER cycles while held.
// Ports:
//   clk      in  system clock, rising edge
//   rst      in  asynchronous active-low reset
//   i_btn    in  button level
//   i_clr    in  restart the repeat timing from the initial delay
//   o_event  out one-cycle event (combinational from i_btn and state)
// ---------------------------------------------------------------------------
module btn_repeat #(
  parameter logic [31:0] REPEAT_DLY = 32'd50_000_000,
  parameter logic [31:0] REPEAT_PER = 32'd10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  input  logic i_clr,
  output logic o_event
);

  localparam logic [31:0] MAX_P = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int          CNT_W = $clog2(MAX_P + 32'd1);

  logic             r_armed;     // low for the first cycle after reset
  logic             r_btn_d;
  logic             r_active;    // held since a real press edge
  logic             r_rep_phase; // 0: waiting REPEAT_DLY, 1: repeating at REPEAT_PER
  logic [CNT_W-1:0] r_cnt;

  logic             w_edge;
  logic             w_rep;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [31:0]      w_target;

  // A button already high when reset releases is neither an edge nor a hold.
  assign w_edge    = r_armed & i_btn & ~r_btn_d;
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_target  = r_rep_phase ? REPEAT_PER : REPEAT_DLY;
  assign w_rep     = r_active & i_btn & (32'(w_cnt_inc) == w_target);
  assign o_event   = w_edge | w_rep;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_armed     <= 1'b0;
      r_btn_d     <= 1'b0;
      r_active    <= 1'b0;
      r_rep_phase <= 1'b0;
      r_cnt       <= '0;
    end else begin
      r_armed <= 1'b1;
      r_btn_d <= i_btn;
      if (!i_btn) begin
        r_active    <= 1'b0;
        r_rep_phase <= 1'b0;
        r_cnt       <= '0;
      end else if (w_edge) begin
        r_active    <= 1'b1;
        r_rep_phase <= 1'b0;
        r_cnt       <= '0;
      end else if (i_clr) begin
        // keep r_active: a continued hold repeats again after REPEAT_DLY
        r_rep_phase <= 1'b0;
        r_cnt       <= '0;
      end else if (w_rep) begin
        r_rep_phase <= 1'b1;
        r_cnt       <= '0;
      end else if (r_active) begin
        r_cnt <= w_cnt_inc;
      end
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// ---------------------------------------------------------------------------
// time_set_ctrl
// Setting controller for the hr:min:sec counter. A mode press walks
// RUN -> SET_HR -> SET_MIN -> SET_SEC -> RUN; inc presses/holds edit the
// selected shadow field with wrap. Leaving SET_SEC issues a one-cycle load
// of the shadow values; an idle timeout in any SET state abandons the edit.
// Ports:
//   clk, rst                 clock (rising edge), async active-low reset
//   btn_mode, btn_inc        debounced, synchronised button levels
//   cur_hr/cur_min/cur_sec   live counter value, captured on entering SET_HR
//   cnt_en                   counter enable, high only in RUN
//   load                     one-cycle load pulse for ld_*
//   ld_hr/ld_min/ld_sec      shadow values
//   set_field                field being edited (one-to-one with FSM state,
//                            so it doubles as the state debug view)
//   blink                    blink for the edited field, 0 in RUN
// ---------------------------------------------------------------------------
module time_set_ctrl
  import time_ctrl_pkg::*;
#(
  parameter logic [31:0] REPEAT_DLY = 32'd50_000_000,
  parameter logic [31:0] REPEAT_PER = 32'd10_000_000,
  parameter logic [31:0] TIMEOUT    = 32'd500_000_000,
  parameter logic [31:0] BLINK_PER  = 32'd25_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_mode,
  input  logic             btn_inc,
  input  logic [SEC_W-1:0] cur_sec,
  input  logic [MIN_W-1:0] cur_min,
  input  logic [HR_W-1:0]  cur_hr,
  output logic             cnt_en,
  output logic             load,
  output logic [SEC_W-1:0] ld_sec,
  output logic [MIN_W-1:0] ld_min,
  output logic [HR_W-1:0]  ld_hr,
  output logic [1:0]       set_field,
  output logic             blink
);

  localparam int TO_W = $clog2(TIMEOUT + 32'd1);
  localparam int BL_W = $clog2(BLINK_PER + 32'd1);

  state_t           r_state;
  state_t           w_state_next;
  logic             r_armed;
  logic             r_mode_d;
  logic             r_load;
  logic             r_blink;
  logic [TO_W-1:0]  r_to_cnt;
  logic [BL_W-1:0]  r_bl_cnt;
  logic [SEC_W-1:0] r_ld_sec;
  logic [MIN_W-1:0] r_ld_min;
  logic [HR_W-1:0]  r_ld_hr;

  logic w_mode_edge;
  logic w_inc_event;
  logic w_to_hit;
  logic w_bl_hit;
  logic w_timeout;
  logic w_state_change;

  assign w_mode_edge = r_armed & btn_mode & ~r_mode_d;

  // Repeat timing restarts on every state change so a held inc does not
  // leak into the newly selected field before the full initial delay.
  btn_repeat #(
    .REPEAT_DLY (REPEAT_DLY),
    .REPEAT_PER (REPEAT_PER)
  ) u_inc_rep (
    .clk     (clk),
    .rst     (rst),
    .i_btn   (btn_inc),
    .i_clr   (w_state_change),
    .o_event (w_inc_event)
  );

  assign w_to_hit = (32'(r_to_cnt) == TIMEOUT - 32'd1);
  assign w_bl_hit = (32'(r_bl_cnt) == BLINK_PER - 32'd1);

  always_comb begin
    w_state_next = r_state;
    w_timeout    = 1'b0;
    if ((r_state != RUN) && !w_mode_edge && !w_inc_event && w_to_hit) begin
      w_timeout = 1'b1;
    end
    case (r_state)
      RUN:     if (w_mode_edge) w_state_next = SET_HR;
      SET_HR:  if (w_mode_edge) w_state_next = SET_MIN;
               else if (w_timeout) w_state_next = RUN;
      SET_MIN: if (w_mode_edge) w_state_next = SET_SEC;
               else if (w_timeout) w_state_next = RUN;
      SET_SEC: if (w_mode_edge || w_timeout) w_state_next = RUN;
      default: w_state_next = RUN;
    endcase
  end

  assign w_state_change = (w_state_next != r_state);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= RUN;
      r_armed  <= 1'b0;
      r_mode_d <= 1'b0;
      // Only a mode press out of SET_SEC commits; a timeout exit does not.
      r_load   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_armed  <= 1'b1;
      r_mode_d <= btn_mode;
      r_load   <= (r_state == SET_SEC) && w_mode_edge;
    end
  end

  // Idle timer: only advances while sitting in a SET state with no activity.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_to_cnt <= '0;
    end else if ((r_state == RUN) || w_state_change || w_mode_edge || w_inc_event) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  // Blink restarts high whenever a new field is selected.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_blink  <= 1'b0;
      r_bl_cnt <= '0;
    end else if (w_state_next == RUN) begin
      r_blink  <= 1'b0;
      r_bl_cnt <= '0;
    end else if (w_state_change) begin
      r_blink  <= 1'b1;
      r_bl_cnt <= '0;
    end else if (w_bl_hit) begin
      r_blink  <= ~r_blink;
      r_bl_cnt <= '0;
    end else begin
      r_bl_cnt <= r_bl_cnt + 1'b1;
    end
  end

  // Shadow registers: capture on entry to editing, then wrap-increment the
  // selected field. A mode press in the same cycle as inc drops the inc.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ld_hr  <= '0;
      r_ld_min <= '0;
      r_ld_sec <= '0;
    end else if (r_state == RUN) begin
      if (w_mode_edge) begin
        r_ld_hr  <= cur_hr;
        r_ld_min <= cur_min;
        r_ld_sec <= cur_sec;
      end
    end else if (w_inc_event && !w_mode_edge) begin
      case (r_state)
        SET_HR:  r_ld_hr  <= inc_hr(r_ld_hr);
        SET_MIN: r_ld_min <= inc_min_sec(r_ld_min);
        SET_SEC: r_ld_sec <= inc_min_sec(r_ld_sec);
        default: ;
      endcase
    end
  end

  always_comb begin
    set_field = FIELD_NONE;
    case (r_state)
      SET_HR:  set_field = FIELD_HR;
      SET_MIN: set_field = FIELD_MIN;
      SET_SEC: set_field = FIELD_SEC;
      default: set_field = FIELD_NONE;
    endcase
  end

  assign cnt_en = (r_state == RUN);
  assign load   = r_load;
  assign blink  = r_blink;
  assign ld_hr  = r_ld_hr;
  assign ld_min = r_ld_min;
  assign ld_sec = r_ld_sec;

endmodule

// File: tb/tb_time_set_ctrl.sv
// ---------------------------------------------------------------------------
// tb_time_set_ctrl
// Table-driven bench for time_set_ctrl with small timing parameters
// (REPEAT_DLY=4, REPEAT_PER=2, TIMEOUT=50, BLINK_PER=3). Each table row
// holds the inputs for one clock edge and the outputs expected after it.
// Output word: {cnt_en, load, ld_hr[4:0], ld_min[5:0], ld_sec[5:0],
// set_field[1:0], blink}; a row with blink don't-care masks bit 0.
// ---------------------------------------------------------------------------
module tb_time_set_ctrl;

  localparam int W = 22;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [5:0] cur_sec = 6'd0;
  logic [5:0] cur_min = 6'd0;
  logic [4:0] cur_hr = 5'd0;
  logic       cnt_en;
  logic       load;
  logic [5:0] ld_sec;
  logic [5:0] ld_min;
  logic [4:0] ld_hr;
  logic [1:0] set_field;
  logic       blink;

  typedef struct {
    logic         mode;
    logic         inc;
    logic [4:0]   hr;
    logic [5:0]   mn;
    logic [5:0]   sc;
    logic [W-1:0] exp;
    logic [W-1:0] mask;
  } vec_t;

  vec_t         tbl[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mask_q[$];
  string        name_q[$];
  int           errors = 0;
  int           checks = 0;
  int           rep_min[10] = '{1, 1, 1, 1, 2, 2, 3, 3, 4, 4};

  time_set_ctrl #(
    .REPEAT_DLY (32'd4),
    .REPEAT_PER (32'd2),
    .TIMEOUT    (32'd50),
    .BLINK_PER  (32'd3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_mode  (btn_mode),
    .btn_inc   (btn_inc),
    .cur_sec   (cur_sec),
    .cur_min   (cur_min),
    .cur_hr    (cur_hr),
    .cnt_en    (cnt_en),
    .load      (load),
    .ld_sec    (ld_sec),
    .ld_min    (ld_min),
    .ld_hr     (ld_hr),
    .set_field (set_field),
    .blink     (blink)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] pk(input logic en, input logic ld, input int h,
                                      input int m, input int s, input int f, input int b);
    logic [W-1:0] r;
    r = {en, ld, 5'(h), 6'(m), 6'(s), 2'(f), (b == 1)};
    return r;
  endfunction

  // b: expected blink, or -1 for don't care
  function automatic vec_t v(input logic md, input logic ic, input int ch, input int cm,
                             input int cs, input logic en, input logic ld, input int h,
                             input int m, input int s, input int f, input int b);
    vec_t r;
    r.mode = md;
    r.inc  = ic;
    r.hr   = 5'(ch);
    r.mn   = 6'(cm);
    r.sc   = 6'(cs);
    r.exp  = pk(en, ld, h, m, s, f, b);
    r.mask = (b < 0) ? 22'h3FFFFE : 22'h3FFFFF;
    return r;
  endfunction

  // scoreboard compare
  task automatic check_out();
    logic [W-1:0] act;
    logic [W-1:0] e;
    logic [W-1:0] m;
    string        nm;
    act = {cnt_en, load, ld_hr, ld_min, ld_sec, set_field, blink};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: output with no expected entry, got %h", act);
      return;
    end
    e  = exp_q.pop_front();
    m  = mask_q.pop_front();
    nm = name_q.pop_front();
    if ((act & m) !== (e & m)) begin
      errors++;
      $display("FAIL %s: got en=%b load=%b ld=%0d:%0d:%0d field=%b blink=%b, expected en=%b load=%b ld=%0d:%0d:%0d field=%b blink=%b (blink checked=%b)",
               nm, act[21], act[20], act[19:15], act[14:9], act[8:3], act[2:1], act[0],
               e[21], e[20], e[19:15], e[14:9], e[8:3], e[2:1], e[0], m[0]);
    end
  endtask

  // driver: apply one row before the edge, compare just after it
  task automatic drive(input vec_t x, input string nm);
    @(negedge clk);
    btn_mode = x.mode;
    btn_inc  = x.inc;
    cur_hr   = x.hr;
    cur_min  = x.mn;
    cur_sec  = x.sc;
    exp_q.push_back(x.exp);
    mask_q.push_back(x.mask);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    // mode held high through reset release: must not count as a press
    cur_hr   = 5'd12;
    cur_min  = 6'd34;
    cur_sec  = 6'd56;
    btn_mode = 1'b1;
    rst      = 1'b0;

    // walk with edits: hr +2, min +1, sec +0, then commit
    tbl.push_back(v(1,0, 12,34,56, 1,0,  0, 0, 0, 0,0));
    tbl.push_back(v(1,0, 12,34,56, 1,0,  0, 0, 0, 0,0));
    tbl.push_back(v(0,0, 12,34,56, 1,0,  0, 0, 0, 0,0));
    tbl.push_back(v(1,0, 12,34,56, 0,0, 12,34,56, 1,1));
    tbl.push_back(v(1,0, 12,34,56, 0,0, 12,34,56, 1,1));
    tbl.push_back(v(0,1, 12,34,56, 0,0, 13,34,56, 1,1));
    tbl.push_back(v(0,0, 12,34,56, 0,0, 13,34,56, 1,0));
    tbl.push_back(v(0,1, 12,34,56, 0,0, 14,34,56, 1,0));
    tbl.push_back(v(0,0, 12,34,56, 0,0, 14,34,56, 1,0));
    tbl.push_back(v(1,0, 12,34,56, 0,0, 14,34,56, 2,1));
    tbl.push_back(v(0,1, 12,34,56, 0,0, 14,35,56, 2,1));
    tbl.push_back(v(0,0, 12,34,56, 0,0, 14,35,56, 2,1));
    tbl.push_back(v(1,0, 12,34,56, 0,0, 14,35,56, 3,1));
    tbl.push_back(v(0,0, 12,34,56, 0,0, 14,35,56, 3,1));
    tbl.push_back(v(1,0, 12,34,56, 1,1, 14,35,56, 0,0));
    tbl.push_back(v(0,0, 12,34,56, 1,0, 14,35,56, 0,0));
    // wrap hr 23->0, sec 59->0 (min untouched); mode+inc same cycle; inc in RUN
    tbl.push_back(v(1,0, 23,10,59, 0,0, 23,10,59, 1,1));
    tbl.push_back(v(0,1, 23,10,59, 0,0,  0,10,59, 1,1));
    tbl.push_back(v(1,0, 23,10,59, 0,0,  0,10,59, 2,1));
    tbl.push_back(v(0,0, 23,10,59, 0,0,  0,10,59, 2,1));
    tbl.push_back(v(1,0, 23,10,59, 0,0,  0,10,59, 3,1));
    tbl.push_back(v(0,1, 23,10,59, 0,0,  0,10, 0, 3,1));
    tbl.push_back(v(0,0, 23,10,59, 0,0,  0,10, 0, 3,1));
    tbl.push_back(v(1,1, 23,10,59, 1,1,  0,10, 0, 0,0));
    tbl.push_back(v(0,0, 23,10,59, 1,0,  0,10, 0, 0,0));
    tbl.push_back(v(0,1, 23,10,59, 1,0,  0,10, 0, 0,0));
    tbl.push_back(v(0,0, 23,10,59, 1,0,  0,10, 0, 0,0));
    // auto-repeat in SET_MIN from 0: events at edge, +4, +6, +8
    tbl.push_back(v(1,0, 5,0,30, 0,0, 5,0,30, 1,-1));
    tbl.push_back(v(0,0, 5,0,30, 0,0, 5,0,30, 1,-1));
    tbl.push_back(v(1,0, 5,0,30, 0,0, 5,0,30, 2,-1));
    tbl.push_back(v(0,0, 5,0,30, 0,0, 5,0,30, 2,-1));
    for (int i = 0; i < 10; i++) begin
      tbl.push_back(v(0,1, 5,0,30, 0,0, 5,rep_min[i],30, 2,-1));
    end
    tbl.push_back(v(0,0, 5,0,30, 0,0, 5,4,30, 2,-1));
    // inc held across a mode press: next event only REPEAT_DLY after the change
    tbl.push_back(v(0,1, 5,0,30, 0,0, 5,5,30, 2,-1));
    tbl.push_back(v(0,1, 5,0,30, 0,0, 5,5,30, 2,-1));
    tbl.push_back(v(1,1, 5,0,30, 0,0, 5,5,30, 3,-1));
    tbl.push_back(v(0,1, 5,0,30, 0,0, 5,5,30, 3,-1));
    tbl.push_back(v(0,1, 5,0,30, 0,0, 5,5,30, 3,-1));
    tbl.push_back(v(0,1, 5,0,30, 0,0, 5,5,30, 3,-1));
    tbl.push_back(v(0,1, 5,0,30, 0,0, 5,5,31, 3,-1));
    tbl.push_back(v(0,0, 5,0,30, 0,0, 5,5,31, 3,-1));
    tbl.push_back(v(1,0, 5,0,30, 1,1, 5,5,31, 0,0));
    tbl.push_back(v(0,0, 5,0,30, 1,0, 5,5,31, 0,0));
    // enter SET_MIN for the idle timeout sequence
    tbl.push_back(v(1,0, 7,8,9, 0,0, 7,8,9, 1,-1));
    tbl.push_back(v(0,0, 7,8,9, 0,0, 7,8,9, 1,-1));
    tbl.push_back(v(1,0, 7,8,9, 0,0, 7,8,9, 2,-1));

    // reset state
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(pk(1,0, 0,0,0, 0,0));
    mask_q.push_back('1);
    name_q.push_back("reset");
    check_out();
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i], $sformatf("vec%0d", i));
    end

    // idle timeout: still SET_MIN after 49 idle edges, RUN after 50, no load
    for (int k = 1; k <= 51; k++) begin
      vec_t x;
      if (k < 50) x = v(0,0, 7,8,9, 0,0, 7,8,9, 2,-1);
      else        x = v(0,0, 7,8,9, 1,0, 7,8,9, 0,0);
      drive(x, $sformatf("idle%0d", k));
    end

    // asynchronous reset in the middle of a SET state
    drive(v(1,0, 7,8,9, 0,0, 7,8,9, 1,1), "rst_pre");
    @(negedge clk);
    btn_mode = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    exp_q.push_back(pk(1,0, 0,0,0, 0,0));
    mask_q.push_back('1);
    name_q.push_back("rst_mid_set");
    check_out();
    @(negedge clk);
    rst = 1'b1;
    drive(v(0,0, 7,8,9, 1,0, 0,0,0, 0,0), "rst_after");
    drive(v(1,0, 7,8,9, 0,0, 7,8,9, 1,1), "rst_reenter");

    // final report
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
